// File: rtl/trig_taylor_pkg.sv
// Shared types and elaboration-time constants for the Taylor sin/cos sequencer.
package trig_taylor_pkg;

    localparam int MAX_TERMS = 8;

    typedef enum logic [2:0] {IDLE, SQ, MUL_T, MUL_C, FINAL, HOLD} state_e;

    function automatic longint ONE(input int frac_w);
        return longint'(1) <<< frac_w;
    endfunction

    // mode 0 = sin: 1/((2k)(2k+1)); mode 1 = cos: 1/((2k-1)(2k)); rounded to nearest
    function automatic longint coef(input int k, input logic mode, input int frac_w);
        longint d;
        d = mode ? longint'((2*k-1)*(2*k)) : longint'((2*k)*(2*k+1));
        if (d <= 0) return 0;
        return (ONE(frac_w) + d/2) / d;
    endfunction

endpackage

// File: rtl/trig_qmul.sv
// Combinational signed fixed-point multiply: full product, keep bits [FRAC_W+DATA_W-1:FRAC_W].
module trig_qmul #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 24
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] p_o
);
    logic signed [2*DATA_W-1:0] prod;
    logic                       unused_bits;

    assign prod        = a_i * b_i;
    assign p_o         = prod[FRAC_W+DATA_W-1:FRAC_W];
    assign unused_bits = ^{prod[2*DATA_W-1:FRAC_W+DATA_W], prod[FRAC_W-1:0]};
endmodule

// File: rtl/trig_taylor_seq.sv
// Sequential Horner-form Taylor sin/cos over one shared multiplier.
// Define TRIG_TAYLOR_SAT_EN to clamp the result to [-ONE, +ONE] and flag it on out_sat.
module trig_taylor_seq
    import trig_taylor_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FRAC_W    = 24,
    parameter int NUM_TERMS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic                     in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_y,
    output logic                     out_sat
);
    localparam logic signed [DATA_W-1:0] ONE_C = DATA_W'(ONE(FRAC_W));

    logic signed [DATA_W-1:0] coef_sin [MAX_TERMS];
    logic signed [DATA_W-1:0] coef_cos [MAX_TERMS];

    for (genvar g = 0; g < MAX_TERMS; g++) begin : g_coef
        assign coef_sin[g] = DATA_W'(coef(g, 1'b0, FRAC_W));
        assign coef_cos[g] = DATA_W'(coef(g, 1'b1, FRAC_W));
    end

    state_e                   state_q;
    logic signed [DATA_W-1:0] x_q, x2_q, acc_q, t_q, out_y_q;
    logic [2:0]               k_q;
    logic                     mode_q, out_valid_q, out_sat_q;

    logic signed [DATA_W-1:0] mul_a, mul_b, prod, diff, res, res_d;
    logic                     sat_d, fin;

    trig_qmul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul (
        .a_i(mul_a), .b_i(mul_b), .p_o(prod)
    );

    always_comb begin
        mul_a = acc_q;
        mul_b = x_q;
        case (state_q)
            SQ:      begin mul_a = x_q;   mul_b = x_q;  end
            MUL_T:   begin mul_a = acc_q; mul_b = x2_q; end
            MUL_C:   begin mul_a = t_q;   mul_b = mode_q ? coef_cos[k_q] : coef_sin[k_q]; end
            default: begin mul_a = acc_q; mul_b = x_q;  end
        endcase
    end

    assign diff = ONE_C - prod;

    // fin marks the cycle whose result is loaded into the output register
    always_comb begin
        fin = 1'b0;
        res = diff;
        case (state_q)
            SQ:      begin fin = (NUM_TERMS == 1) && mode_q; res = ONE_C; end
            MUL_C:   begin fin = (k_q <= 3'd1) && mode_q;     res = diff;  end
            FINAL:   begin fin = 1'b1;                        res = prod;  end
            default: begin fin = 1'b0;                        res = diff;  end
        endcase
    end

`ifdef TRIG_TAYLOR_SAT_EN
    always_comb begin
        res_d = res;
        sat_d = 1'b0;
        if (res > ONE_C) begin
            res_d = ONE_C;
            sat_d = 1'b1;
        end else if (res < -ONE_C) begin
            res_d = -ONE_C;
            sat_d = 1'b1;
        end
    end
`else
    assign res_d = res;
    assign sat_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            x2_q        <= '0;
            acc_q       <= '0;
            t_q         <= '0;
            k_q         <= '0;
            mode_q      <= 1'b0;
            out_y_q     <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    x_q     <= in_x;
                    mode_q  <= in_mode;
                    acc_q   <= ONE_C;
                    k_q     <= 3'(NUM_TERMS - 1);
                    state_q <= SQ;
                end
                SQ: begin
                    x2_q <= prod;
                    if (NUM_TERMS > 1) state_q <= MUL_T;
                    else               state_q <= mode_q ? HOLD : FINAL;
                end
                MUL_T: begin
                    t_q     <= prod;
                    state_q <= MUL_C;
                end
                MUL_C: begin
                    acc_q <= diff;
                    k_q   <= k_q - 3'd1;
                    if (k_q > 3'd1) state_q <= MUL_T;
                    else            state_q <= mode_q ? HOLD : FINAL;
                end
                FINAL: state_q <= HOLD;
                HOLD: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (fin) begin
                out_y_q     <= res_d;
                out_sat_q   <= sat_d;
                out_valid_q <= 1'b1;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_trig_taylor_seq.sv
// Directed scoreboard bench for trig_taylor_seq (default instance plus a NUM_TERMS=2 instance).
module tb_trig_taylor_seq;
    localparam int DW = 32;
    localparam longint ONEV = 16777216;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 in_valid, in_ready, in_mode, out_valid, out_ready, out_sat;
    logic signed [DW-1:0] in_x, out_y;
    logic                 in_valid_b, in_ready_b, in_mode_b, out_valid_b, out_ready_b, out_sat_b;
    logic signed [DW-1:0] in_x_b, out_y_b;

    trig_taylor_seq #(.DATA_W(32), .FRAC_W(24), .NUM_TERMS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_sat(out_sat)
    );

    trig_taylor_seq #(.DATA_W(32), .FRAC_W(24), .NUM_TERMS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_x(in_x_b),
        .in_mode(in_mode_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_y(out_y_b),
        .out_sat(out_sat_b)
    );

    typedef struct {
        longint y;
        longint tol;
        logic   sat;
        int     lat;
    } exp_t;

    exp_t sb[$];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs, input longint exp, input longint tol);
        logic ok;
        ok = ((obs - exp) <= tol) && ((exp - obs) <= tol);
        checks++;
        assert (ok === 1'b1) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // counts rising edges after the accept edge until out_valid is seen
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 40);
    endtask

    task automatic check_pop(input string tag, input int n);
        exp_t e;
        e = sb.pop_front();
        chk({tag, " latency"}, n, e.lat);
        chk_tol({tag, " y"}, out_y, e.y, e.tol);
        chk({tag, " sat"}, out_sat, e.sat);
    endtask

    task automatic op(input string tag, input logic signed [DW-1:0] x, input logic m,
                      input longint ey, input longint tol, input int lat, output longint y);
        int n;
        sb.push_back('{y: ey, tol: tol, sat: 1'b0, lat: lat});
        @(negedge clk);
        wait_ready();
        in_x     = x;
        in_mode  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x     = $urandom;
        in_mode  = ~m;
        wait_out(n);
        y = out_y;
        check_pop(tag, n);
    endtask

    initial begin
        longint y1, y2, y0, yd;
        int     n;
        logic   bad;

        rst = 1'b1;
        in_valid = 1'b0; in_x = '0; in_mode = 1'b0; out_ready = 1'b1;
        in_valid_b = 1'b0; in_x_b = '0; in_mode_b = 1'b0; out_ready_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_y", out_y, 0);
        chk("reset out_sat", out_sat, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", in_ready, 1);

        op("sin0", 0, 1'b0, 0, 0, 8, y1);
        op("cos0", 0, 1'b1, ONEV, 0, 7, y1);
        op("sin+pi2", 26353589, 1'b0, ONEV, 5000, 8, y1);
        op("sin-pi2", -26353589, 1'b0, -ONEV, 5000, 8, y2);
        chk_tol("sin odd symmetry", y1 + y2, 0, 2);
        op("sin0.5", 8388608, 1'b0, 8043426, 200, 8, y1);
        op("cos0.5", 8388608, 1'b1, 14723392, 200, 7, y1);
        op("cos-0.5", -8388608, 1'b1, 14723392, 200, 7, y1);

        // backpressure with in_valid held high throughout
        @(negedge clk);
        wait_ready();
        sb.push_back('{y: 8043426, tol: 200, sat: 1'b0, lat: 8});
        out_ready = 1'b0;
        in_x      = 8388608;
        in_mode   = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        wait_out(n);
        y0 = out_y;
        check_pop("bp first", n);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp out_y stable", out_y, y0);
            chk("bp out_valid held", out_valid, 1);
            chk("bp in_ready low", in_ready, 0);
        end
        sb.push_back('{y: 8043426, tol: 200, sat: 1'b0, lat: 8});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp handshake out_valid", out_valid, 0);
        chk("bp handshake in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("bp next accept", in_ready, 0);
        in_valid = 1'b0;
        wait_out(n);
        check_pop("bp second", n);

        // reset three edges into an operation
        @(negedge clk);
        wait_ready();
        in_x = 8388608; in_mode = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort in_ready", in_ready, 1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) bad = 1'b1;
        end
        chk("abort no output", bad, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post-abort in_ready", in_ready, 1);
        op("post-abort cos0", 0, 1'b1, ONEV, 0, 7, y1);

        // NUM_TERMS=2 instance, cos(3.0)
        @(negedge clk);
        in_x_b = 50331648; in_mode_b = 1'b1; in_valid_b = 1'b1;
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid_b && n < 40);
        chk("n2 cos3 latency", n, 3);
        yd = out_y_b;
`ifdef TRIG_TAYLOR_SAT_EN
        chk("n2 cos3 y", yd, -16777216);
        chk("n2 cos3 sat", out_sat_b, 1);
`else
        chk("n2 cos3 y", yd, -58720256);
        chk("n2 cos3 sat", out_sat_b, 0);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/trig_taylor_seq.md
TRIG_TAYLOR_SEQ -- requirements
Module: trig_taylor_seq

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32: signed fixed-point word width.
REQ-002 The block SHALL take parameter FRAC_W, default 24: fractional bits (default Q8.24); legal when FRAC_W <= DATA_W-3.
REQ-003 The block SHALL take parameter NUM_TERMS, default 4: Taylor terms, legal range 1..8.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
  clk        in   1       sole clock; all state changes on its rising edge
  rst        in   1       asynchronous, active-high reset
  in_valid   in   1       operand valid
  in_ready   out  1       block can accept an operand
  in_x       in   DATA_W  signed angle, Q(DATA_W-FRAC_W).FRAC_W
  in_mode    in   1       0 = sin, 1 = cos
  out_valid  out  1       result valid
  out_ready  in   1       consumer accepts result
  out_y      out  DATA_W  signed result, same Q format
  out_sat    out  1       result was clamped

Function
REQ-005 The block SHALL evaluate by Horner iteration with one shared multiplier: acc <- ONE; for k = NUM_TERMS-1 down to 1: t <- acc*x2; acc <- ONE - t*c_k.
REQ-006 Coefficients SHALL be c_k = round(2^FRAC_W / ((2k)(2k+1))) for sin and round(2^FRAC_W / ((2k-1)(2k))) for cos, computed at elaboration.
REQ-007 Every multiply SHALL form a full 2*DATA_W signed product and take bits [FRAC_W+DATA_W-1 : FRAC_W], truncating toward minus infinity; add/subtract SHALL wrap at DATA_W bits.
REQ-008 The result SHALL be acc*x for sin and acc for cos.
REQ-009 The FSM SHALL use the states IDLE, SQ, MUL_T, MUL_C, FINAL and HOLD.
  - IDLE to SQ on accept.
  - SQ to MUL_T if NUM_TERMS > 1; otherwise to FINAL (sin) or HOLD (cos).
  - MUL_T to MUL_C.
  - MUL_C to MUL_T while k > 1; otherwise to FINAL (sin) or HOLD (cos).
  - FINAL to HOLD.
  - HOLD to IDLE on out_ready.
REQ-010 in_ready SHALL equal (state == IDLE); an accept SHALL occur when in_valid && in_ready; in_x and in_mode SHALL be latched on the accept edge.
REQ-011 out_valid SHALL rise on the 2*NUM_TERMS-th rising edge after the accept edge for sin, and on the (2*NUM_TERMS-1)-th for cos.
REQ-012 out_y, out_sat and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-013 The block SHALL deassert out_valid on the edge where out_valid && out_ready; in_ready SHALL rise on that same edge (one bubble cycle; no accept while in HOLD).
REQ-014 in_x and in_mode changes while not accepting SHALL have no effect.
REQ-015 Accuracy is specified for |x| <= pi/2; other inputs SHALL be processed identically with no error flag.

Reset
REQ-016 On rst the block SHALL immediately force: state IDLE, out_valid 0, out_y 0, out_sat 0, acc/x/x2/counter 0.
REQ-017 in_ready SHALL be 1 after reset release.
REQ-018 Reset during computation SHALL abort the operation with no output produced.

Configuration
REQ-019 With TRIG_TAYLOR_SAT_EN defined, the block SHALL clamp the final result to [-ONE, +ONE] and set out_sat when clamped.
REQ-020 Without TRIG_TAYLOR_SAT_EN, the result SHALL pass unclamped and out_sat SHALL be tied 0.
REQ-021 Latency SHALL be identical with and without TRIG_TAYLOR_SAT_EN.

Structure
REQ-022 Package trig_taylor_pkg SHALL hold:
  - the state enum;
  - the ONE(FRAC_W) constant function;
  - the coefficient function coef(k, mode, FRAC_W);
  - the MAX_TERMS = 8 constant.
REQ-023 Sub-module trig_qmul (registered-free signed multiply plus FRAC_W shift per REQ-007) SHALL be the only multiplier instance.

Verification (defaults DATA_W=32, FRAC_W=24, NUM_TERMS=4)
REQ-024 sin, x=0, out_ready=1: out_valid SHALL rise 8 edges after accept; out_y=0; out_sat=0.
REQ-025 cos, x=0: out_valid SHALL rise 7 edges after accept; out_y=16777216 exactly.
REQ-026 sin, x=26353589 (pi/2): out_y SHALL be within 16777216 +/- 5000; sin, x=-26353589: out_y SHALL be the negated value within +/- 2 LSB.
REQ-027 Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 throughout:
  - out_y SHALL stay stable;
  - in_ready SHALL stay 0;
  - the next accept SHALL occur exactly 1 cycle after the out handshake.
REQ-028 Assert rst 3 cycles after an accept: out_valid SHALL stay 0; in_ready SHALL be 1 after release; a following operation SHALL complete correctly.
REQ-029 NUM_TERMS=2, cos, x=50331648 (3.0), with TRIG_TAYLOR_SAT_EN: out_y=-16777216 and out_sat=1; without the macro: out_y=-58720256 and out_sat=0.
